// File: rtl/execute_alu_mc.sv
// rtl/execute_alu_mc.sv - multi-cycle RV32-style execute ALU with valid/ready handshakes
//
// Purpose: selects operand B, decodes aluop/funct, executes base integer ops
// in one cycle and unsigned MUL/MULHU/DIVU/REMU iteratively (one bit per cycle).
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   in_valid/in_ready   upstream handshake; operands sampled on accept
//   in1, in2, imm       operand A, operand B register, immediate
//   alusrc              1 = operand B is imm
//   aluop, funct        operation select, {funct7, funct3}
//   out_valid/out_ready downstream handshake; result held until consumed
//   aluout, zero        result and result==0
//   illegal             unsupported funct decode (result forced to 0)
//   busy                multiply/divide iteration in progress
module execute_alu_mc #(
  parameter int XLEN          = 32,
  parameter bit ENABLE_MULDIV = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in1,
  input  logic [XLEN-1:0] in2,
  input  logic [XLEN-1:0] imm,
  input  logic            alusrc,
  input  logic [1:0]      aluop,
  input  logic [9:0]      funct,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] aluout,
  output logic            zero,
  output logic            illegal,
  output logic            busy
);

  localparam int SW = $clog2(XLEN);
  localparam int CW = $clog2(XLEN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
  typedef enum logic [1:0] {K_ONE, K_MUL, K_DIV} kind_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] aluout_q, aluout_d;
  logic            illegal_q, illegal_d;
  // acc holds the product high half / partial remainder,
  // lo holds the multiplier being consumed / dividend shifting into quotient.
  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] m_q, m_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            hi_sel_q, hi_sel_d;

  logic [XLEN-1:0] opb;
  logic [SW-1:0]   shamt;
  logic [6:0]      f7;
  logic [2:0]      f3;
  logic [XLEN-1:0] sra_res;
  logic            slt_res;
  logic            sltu_res;
  kind_t           kind;
  logic [XLEN-1:0] res1;
  logic            ill1;
  logic            sel_hi;
  logic            accept;

  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_sh;
  logic [XLEN:0]   div_diff;
  logic            div_ge;
  logic [XLEN-1:0] iter_res;

  assign opb      = alusrc ? imm : in2;
  assign shamt    = opb[SW-1:0];
  assign f7       = funct[9:3];
  assign f3       = funct[2:0];
  assign sra_res  = $unsigned($signed(in1) >>> shamt);
  assign slt_res  = $signed(in1) < $signed(opb);
  assign sltu_res = in1 < opb;

  // Decode into either a one-cycle result or an iterative operation kind.
  always_comb begin
    kind   = K_ONE;
    res1   = '0;
    ill1   = 1'b0;
    sel_hi = 1'b0;
    case (aluop)
      2'd0: res1 = in1 + opb;
      2'd1: res1 = in1 - opb;
      2'd2: begin
        if (f7 == 7'h00) begin
          case (f3)
            3'd0: res1 = in1 + opb;
            3'd1: res1 = in1 << shamt;
            3'd2: res1 = {{(XLEN-1){1'b0}}, slt_res};
            3'd3: res1 = {{(XLEN-1){1'b0}}, sltu_res};
            3'd4: res1 = in1 ^ opb;
            3'd5: res1 = in1 >> shamt;
            3'd6: res1 = in1 | opb;
            default: res1 = in1 & opb;
          endcase
        end else if (f7 == 7'h20 && f3 == 3'd0) begin
          res1 = in1 - opb;
        end else if (f7 == 7'h20 && f3 == 3'd5) begin
          res1 = sra_res;
        end else if (f7 == 7'h01 && ENABLE_MULDIV) begin
          case (f3)
            3'd0: kind = K_MUL;
            3'd3: begin
              kind   = K_MUL;
              sel_hi = 1'b1;
            end
            3'd5: kind = K_DIV;
            3'd7: begin
              kind   = K_DIV;
              sel_hi = 1'b1;
            end
            default: ill1 = 1'b1;
          endcase
        end else begin
          ill1 = 1'b1;
        end
      end
      default: res1 = '0;
    endcase
  end

  // Shift-add multiply step: add multiplicand when the current multiplier
  // bit is set, then shift the {acc, lo} pair right by one.
  assign mul_sum  = {1'b0, acc_q} + (lo_q[0] ? {1'b0, m_q} : '0);

  // Restoring divide step. The partial remainder is always below the divisor,
  // so div_sh < 2*divisor and the top bit of the difference is a clean borrow.
  // A zero divisor never borrows: quotient becomes all ones, remainder the dividend.
  assign div_sh   = {acc_q, lo_q[XLEN-1]};
  assign div_diff = div_sh - {1'b0, m_q};
  assign div_ge   = ~div_diff[XLEN];

  assign iter_res = hi_sel_q ? acc_q : lo_q;

  assign in_ready = (state_q == S_IDLE) || (state_q == S_DONE && out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d   = state_q;
    aluout_d  = aluout_q;
    illegal_d = illegal_q;
    acc_d     = acc_q;
    lo_d      = lo_q;
    m_d       = m_q;
    cnt_d     = cnt_q;
    hi_sel_d  = hi_sel_q;

    case (state_q)
      S_MUL: begin
        if (cnt_q == CNT_LAST) begin
          aluout_d  = iter_res;
          illegal_d = 1'b0;
          state_d   = S_DONE;
        end else begin
          acc_d = mul_sum[XLEN:1];
          lo_d  = {mul_sum[0], lo_q[XLEN-1:1]};
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DIV: begin
        if (cnt_q == CNT_LAST) begin
          aluout_d  = iter_res;
          illegal_d = 1'b0;
          state_d   = S_DONE;
        end else begin
          acc_d = div_ge ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0];
          lo_d  = {lo_q[XLEN-2:0], div_ge};
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: ;
    endcase

    // Accept is only possible from IDLE or a consumed DONE, so it overrides.
    if (accept) begin
      case (kind)
        K_MUL: begin
          state_d  = S_MUL;
          acc_d    = '0;
          lo_d     = opb;
          m_d      = in1;
          cnt_d    = '0;
          hi_sel_d = sel_hi;
        end
        K_DIV: begin
          state_d  = S_DIV;
          acc_d    = '0;
          lo_d     = in1;
          m_d      = opb;
          cnt_d    = '0;
          hi_sel_d = sel_hi;
        end
        default: begin
          state_d   = S_DONE;
          aluout_d  = res1;
          illegal_d = ill1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      aluout_q  <= '0;
      illegal_q <= 1'b0;
      acc_q     <= '0;
      lo_q      <= '0;
      m_q       <= '0;
      cnt_q     <= '0;
      hi_sel_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      aluout_q  <= aluout_d;
      illegal_q <= illegal_d;
      acc_q     <= acc_d;
      lo_q      <= lo_d;
      m_q       <= m_d;
      cnt_q     <= cnt_d;
      hi_sel_q  <= hi_sel_d;
    end
  end

  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_MUL) || (state_q == S_DIV);
  assign aluout    = aluout_q;
  assign illegal   = illegal_q;
  assign zero      = (aluout_q == '0);

endmodule

// File: tb/tb_execute_alu_mc.sv
// tb/tb_execute_alu_mc.sv - directed self-checking bench for execute_alu_mc
module tb_execute_alu_mc;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        in_valid;
  logic        in_valid0;
  logic        out_ready;
  logic        out_ready0;
  logic [31:0] in1, in2, imm;
  logic        alusrc;
  logic [1:0]  aluop;
  logic [9:0]  funct;

  logic        in_ready, out_valid, zero, illegal, busy;
  logic [31:0] aluout;
  logic        in_ready0, out_valid0, zero0, illegal0, busy0;
  logic [31:0] aluout0;

  int checks = 0;
  int errors = 0;

  execute_alu_mc #(.XLEN(32), .ENABLE_MULDIV(1'b1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2), .imm(imm), .alusrc(alusrc), .aluop(aluop), .funct(funct),
    .out_valid(out_valid), .out_ready(out_ready), .aluout(aluout), .zero(zero),
    .illegal(illegal), .busy(busy)
  );

  execute_alu_mc #(.XLEN(32), .ENABLE_MULDIV(1'b0)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid0), .in_ready(in_ready0),
    .in1(in1), .in2(in2), .imm(imm), .alusrc(alusrc), .aluop(aluop), .funct(funct),
    .out_valid(out_valid0), .out_ready(out_ready0), .aluout(aluout0), .zero(zero0),
    .illegal(illegal0), .busy(busy0)
  );

  task automatic drive(input logic [1:0] op, input logic [9:0] f,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] im, input logic src);
    aluop  = op;
    funct  = f;
    in1    = a;
    in2    = b;
    imm    = im;
    alusrc = src;
  endtask

  task automatic issue(input logic [1:0] op, input logic [9:0] f,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] im, input logic src);
    @(negedge clk);
    drive(op, f, a, b, im, src);
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Runs one iterative op to completion; scrambles inputs after accept.
  task automatic long_op(input logic [9:0] f, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [31:0] res, output bit busy_ok);
    issue(2'd2, f, a, b, 32'h0, 1'b0);
    lat     = -1;
    res     = '0;
    busy_ok = 1'b1;
    in1 = $urandom;
    in2 = $urandom;
    @(negedge clk);
    if (!busy || in_ready || out_valid) busy_ok = 1'b0;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) begin
        lat = n;
        res = aluout;
        if (busy) busy_ok = 1'b0;
        break;
      end
      if (!busy || in_ready) busy_ok = 1'b0;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (zero !== 1'b1) begin errors++; $display("FAIL reset_zero: got %b expected 1", zero); end
    checks++; if (illegal !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_flags: got illegal=%b busy=%b expected 0 0", illegal, busy); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    reset = 1'b0;
  endtask

  task automatic test_add;
    issue(2'd2, 10'h000, 32'd5, 32'd7, 32'h0, 1'b0);
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_valid: got %b expected 1", out_valid); end
    checks++; if (aluout !== 32'd12) begin errors++; $display("FAIL add_result: got %h expected %h", aluout, 32'd12); end
    checks++; if (zero !== 1'b0) begin errors++; $display("FAIL add_zero: got %b expected 0", zero); end
  endtask

  task automatic test_sub_imm;
    issue(2'd1, 10'h000, 32'd9, 32'd9, 32'h0, 1'b0);
    @(negedge clk);
    checks++; if (aluout !== 32'd0 || zero !== 1'b1) begin errors++; $display("FAIL branch_sub: got %h zero=%b expected 0 zero=1", aluout, zero); end
    issue(2'd0, 10'h000, 32'd1, 32'd77, 32'hFFFF_FFFF, 1'b1);
    @(negedge clk);
    checks++; if (aluout !== 32'd0 || zero !== 1'b1) begin errors++; $display("FAIL imm_add: got %h zero=%b expected 0 zero=1", aluout, zero); end
    issue(2'd2, 10'h100, 32'd3, 32'd5, 32'h0, 1'b0);
    @(negedge clk);
    checks++; if (aluout !== 32'hFFFF_FFFE) begin errors++; $display("FAIL rtype_sub: got %h expected fffffffe", aluout); end
  endtask

  task automatic test_back_to_back;
    logic [9:0]  bf [4] = '{10'h000, 10'h004, 10'h006, 10'h007};
    logic [31:0] ba [4] = '{32'h1, 32'hF0, 32'h100, 32'hFF};
    logic [31:0] bb [4] = '{32'h2, 32'hFF, 32'h1, 32'h0F};
    logic [31:0] be [4] = '{32'h3, 32'h0F, 32'h101, 32'h0F};
    @(negedge clk);
    drive(2'd2, bf[0], ba[0], bb[0], 32'h0, 1'b0);
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (i < 3) drive(2'd2, bf[i+1], ba[i+1], bb[i+1], 32'h0, 1'b0);
      else in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || aluout !== be[i]) begin
        errors++;
        $display("FAIL b2b_%0d: got valid=%b %h expected valid=1 %h", i, out_valid, aluout, be[i]);
      end
    end
  endtask

  task automatic test_compare_shift;
    issue(2'd2, 10'h002, 32'hFFFF_FFFF, 32'd1, 32'h0, 1'b0);
    @(negedge clk);
    checks++; if (aluout !== 32'd1) begin errors++; $display("FAIL slt: got %h expected 1", aluout); end
    issue(2'd2, 10'h003, 32'hFFFF_FFFF, 32'd1, 32'h0, 1'b0);
    @(negedge clk);
    checks++; if (aluout !== 32'd0) begin errors++; $display("FAIL sltu: got %h expected 0", aluout); end
    issue(2'd2, 10'h105, 32'h8000_0000, 32'd4, 32'h0, 1'b0);
    @(negedge clk);
    checks++; if (aluout !== 32'hF800_0000) begin errors++; $display("FAIL sra: got %h expected f8000000", aluout); end
    issue(2'd2, 10'h005, 32'h8000_0000, 32'd4, 32'h0, 1'b0);
    @(negedge clk);
    checks++; if (aluout !== 32'h0800_0000) begin errors++; $display("FAIL srl: got %h expected 08000000", aluout); end
    issue(2'd2, 10'h001, 32'h1, 32'h3F, 32'h0, 1'b0);
    @(negedge clk);
    checks++; if (aluout !== 32'h8000_0000) begin errors++; $display("FAIL sll_mask: got %h expected 80000000", aluout); end
  endtask

  task automatic test_mul;
    int lat; logic [31:0] res; bit bok;
    long_op(10'h008, 32'h0000_FFFF, 32'h0000_FFFF, lat, res, bok);
    checks++; if (lat != 33) begin errors++; $display("FAIL mul_latency: got %0d expected 33", lat); end
    checks++; if (res !== 32'hFFFE_0001) begin errors++; $display("FAIL mul_result: got %h expected fffe0001", res); end
    checks++; if (!bok) begin errors++; $display("FAIL mul_busy: got busy/in_ready window wrong expected busy=1 in_ready=0"); end
    long_op(10'h00B, 32'hFFFF_FFFF, 32'd2, lat, res, bok);
    checks++; if (res !== 32'd1 || lat != 33) begin errors++; $display("FAIL mulhu: got %h lat=%0d expected 1 lat=33", res, lat); end
  endtask

  task automatic test_div;
    int lat; logic [31:0] res; bit bok; bit seen;
    long_op(10'h00D, 32'd100, 32'd7, lat, res, bok);
    checks++; if (res !== 32'd14 || lat != 33 || !bok) begin errors++; $display("FAIL divu: got %h lat=%0d busy_ok=%b expected 0000000e lat=33 busy_ok=1", res, lat, bok); end
    long_op(10'h00F, 32'd100, 32'd7, lat, res, bok);
    checks++; if (res !== 32'd2 || lat != 33) begin errors++; $display("FAIL remu: got %h lat=%0d expected 2 lat=33", res, lat); end
    long_op(10'h00D, 32'h1234_5678, 32'd0, lat, res, bok);
    checks++; if (res !== 32'hFFFF_FFFF || lat != 33 || illegal !== 1'b0) begin errors++; $display("FAIL divu_by_zero: got %h lat=%0d illegal=%b expected ffffffff lat=33 illegal=0", res, lat, illegal); end
    long_op(10'h00F, 32'd13, 32'd0, lat, res, bok);
    checks++; if (res !== 32'd13 || lat != 33) begin errors++; $display("FAIL remu_by_zero: got %h lat=%0d expected 0000000d lat=33", res, lat); end

    issue(2'd2, 10'h00D, 32'd100, 32'd7, 32'h0, 1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL div_reset_abort: got valid=%b busy=%b in_ready=%b expected 0 0 1", out_valid, busy, in_ready); end
    reset = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL div_reset_no_result: got result emitted=%b expected 0", seen); end
  endtask

  task automatic test_backpressure;
    bit stable;
    out_ready = 1'b0;
    issue(2'd2, 10'h000, 32'd3, 32'd4, 32'h0, 1'b0);
    drive(2'd2, 10'h000, 32'd99, 32'd99, 32'h0, 1'b0);
    in_valid = 1'b1;
    stable = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || aluout !== 32'd7 || in_ready !== 1'b0) stable = 1'b0;
    end
    checks++; if (!stable) begin errors++; $display("FAIL backpressure_hold: got valid=%b %h in_ready=%b expected 1 00000007 0", out_valid, aluout, in_ready); end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL backpressure_release: got valid=%b expected 0", out_valid); end
  endtask

  task automatic test_illegal;
    issue(2'd2, 10'h3F8, 32'd5, 32'd6, 32'h0, 1'b0);
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || aluout !== 32'd0 || illegal !== 1'b1) begin errors++; $display("FAIL illegal_f7: got valid=%b %h illegal=%b expected 1 0 1", out_valid, aluout, illegal); end
    issue(2'd2, 10'h101, 32'd5, 32'd6, 32'h0, 1'b0);
    @(negedge clk);
    checks++; if (aluout !== 32'd0 || illegal !== 1'b1) begin errors++; $display("FAIL illegal_sub_f3: got %h illegal=%b expected 0 1", aluout, illegal); end
    issue(2'd3, 10'h000, 32'd5, 32'd6, 32'h0, 1'b0);
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || aluout !== 32'd0 || illegal !== 1'b0) begin errors++; $display("FAIL nop: got valid=%b %h illegal=%b expected 1 0 0", out_valid, aluout, illegal); end
  endtask

  task automatic test_no_muldiv;
    @(negedge clk);
    drive(2'd2, 10'h008, 32'd3, 32'd5, 32'h0, 1'b0);
    in_valid0 = 1'b1;
    @(posedge clk);
    #1 in_valid0 = 1'b0;
    @(negedge clk);
    checks++; if (out_valid0 !== 1'b1 || illegal0 !== 1'b1 || aluout0 !== 32'd0) begin errors++; $display("FAIL nomuldiv_mul: got valid=%b illegal=%b %h expected 1 1 0", out_valid0, illegal0, aluout0); end
  endtask

  initial begin
    reset      = 1'b1;
    in_valid   = 1'b0;
    in_valid0  = 1'b0;
    out_ready  = 1'b1;
    out_ready0 = 1'b1;
    drive(2'd0, 10'h000, 32'h0, 32'h0, 32'h0, 1'b0);
    test_reset;
    test_add;
    test_sub_imm;
    test_back_to_back;
    test_compare_shift;
    test_mul;
    test_div;
    test_backpressure;
    test_illegal;
    test_no_muldiv;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
